arbitro_calculadora: RTL and testbench



---
 rtl/calc_pkg.sv | 28 ++
 rtl/arbitro_calculadora_rr_arbiter.sv | 40 ++++
 rtl/arbitro_calculadora.sv | 184 ++++++++++++++++++
 tb/tb_arbitro_calculadora.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the Ensamblador arbitration slice.
//   CALC_DATA_W : default operand/result width (must match Ensamblador)
//   OP_*        : encoding of the 3-bit operacion field understood by the unit
//   state_e     : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_DATA_W = 32;

  localparam logic [2:0] OP_SUMA  = 3'd0;
  localparam logic [2:0] OP_RESTA = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_XOR   = 3'd6;
  localparam logic [2:0] OP_NOP   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ESPERA    = 2'd1,
    ST_RESPUESTA = 2'd2,
    ST_LIBERA    = 2'd3
  } state_e;

endpackage

// File: rtl/arbitro_calculadora_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches the request vector upward
// starting at ptr+1 (mod N) and returns the first requester found.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index of the last requester served
//   grant out N   one-hot grant (all zero when no request)
//   idx   out IW  index of the granted requester
//   any   out 1   at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // k = N wraps back onto ptr itself, so the last served requester is
    // only picked again when nobody else is asking.
    for (int k = 1; k <= N; k++) begin
      logic [IW-1:0] j;
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/arbitro_calculadora.sv
// -----------------------------------------------------------------------------
// arbitro_calculadora
// Shares one Ensamblador calculation unit between N requesters. Round-robin
// grant, operand capture, start/ready sequencing and routing of the result back
// to the requester that issued the operation.
//
// Optional build macro: CALC_TIMEOUT_EN -- adds a watchdog in ESPERA; after
// TIMEOUT cycles without calc_ready the operation completes with
// resp_error=1 and resp_resultado=0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid[N]             pending operation per requester (level)
//   req_datoA/req_datoB      N packed DATA_W operand slices
//   req_operacion            N packed 3-bit opcode slices
//   req_accept[N]            one-cycle pulse: operands of requester i captured
//   resp_valid[N]            one-cycle pulse: result for requester i
//   resp_resultado/error     shared response bus, held between pulses
//   ocupado                  FSM not in IDLE
//   calc_datoA/B/operacion   operands toward Ensamblador
//   calc_start               start toward Ensamblador
//   calc_resultado/ready/error  response from Ensamblador
// -----------------------------------------------------------------------------
module arbitro_calculadora
  import calc_pkg::*;
#(
  parameter int N       = 2,
  parameter int DATA_W  = CALC_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  input  logic [N*DATA_W-1:0]   req_datoA,
  input  logic [N*DATA_W-1:0]   req_datoB,
  input  logic [N*3-1:0]        req_operacion,
  output logic [N-1:0]          req_accept,
  output logic [N-1:0]          resp_valid,
  output logic [DATA_W-1:0]     resp_resultado,
  output logic                  resp_error,
  output logic                  ocupado,
  output logic [DATA_W-1:0]     calc_datoA,
  output logic [DATA_W-1:0]     calc_datoB,
  output logic [2:0]            calc_operacion,
  output logic                  calc_start,
  input  logic [DATA_W-1:0]     calc_resultado,
  input  logic                  calc_ready,
  input  logic                  calc_error
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 4) begin : g_bad_n
    $error("arbitro_calculadora: N must be in 2..4");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("arbitro_calculadora: TIMEOUT must be at least 1");
  end

  // Unpack the per-requester slices so the capture mux reads naturally.
  logic [DATA_W-1:0] dato_a_arr [N];
  logic [DATA_W-1:0] dato_b_arr [N];
  logic [2:0]        oper_arr   [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign dato_a_arr[gi] = req_datoA[gi*DATA_W +: DATA_W];
    assign dato_b_arr[gi] = req_datoB[gi*DATA_W +: DATA_W];
    assign oper_arr[gi]   = req_operacion[gi*3 +: 3];
  end

  state_e            state_q;
  logic [IW-1:0]     ptr_q;
  logic [N-1:0]      owner_q;      // one-hot of the requester in flight
  logic [N-1:0]      req_accept_q;
  logic [N-1:0]      resp_valid_q;
  logic [DATA_W-1:0] resp_resultado_q;
  logic              resp_error_q;
  logic [DATA_W-1:0] calc_datoA_q;
  logic [DATA_W-1:0] calc_datoB_q;
  logic [2:0]        calc_operacion_q;
  logic              calc_start_q;

  logic [N-1:0]      gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;

`ifdef CALC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  tmo_cnt_q;
`endif

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      ptr_q            <= IW'(N - 1);
      owner_q          <= '0;
      req_accept_q     <= '0;
      resp_valid_q     <= '0;
      resp_resultado_q <= '0;
      resp_error_q     <= 1'b0;
      calc_datoA_q     <= '0;
      calc_datoB_q     <= '0;
      calc_operacion_q <= '0;
      calc_start_q     <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      tmo_cnt_q        <= '0;
`endif
    end else begin
      // Both handshakes toward the requesters are single-cycle pulses.
      req_accept_q <= '0;
      resp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            calc_datoA_q     <= dato_a_arr[gnt_idx];
            calc_datoB_q     <= dato_b_arr[gnt_idx];
            calc_operacion_q <= oper_arr[gnt_idx];
            calc_start_q     <= 1'b1;
            req_accept_q     <= gnt;
            owner_q          <= gnt;
            ptr_q            <= gnt_idx;
            state_q          <= ST_ESPERA;
`ifdef CALC_TIMEOUT_EN
            tmo_cnt_q        <= '0;
`endif
          end
        end
        ST_ESPERA: begin
          if (calc_ready) begin
            resp_resultado_q <= calc_resultado;
            resp_error_q     <= calc_error;
            resp_valid_q     <= owner_q;
            calc_start_q     <= 1'b0;
            state_q          <= ST_RESPUESTA;
          end
`ifdef CALC_TIMEOUT_EN
          else if (tmo_cnt_q == CNT_W'(TIMEOUT)) begin
            resp_resultado_q <= '0;
            resp_error_q     <= 1'b1;
            resp_valid_q     <= owner_q;
            calc_start_q     <= 1'b0;
            state_q          <= ST_RESPUESTA;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
`endif
        end
        ST_RESPUESTA: begin
          state_q <= ST_LIBERA;
        end
        ST_LIBERA: begin
          // Do not re-arm until the unit has withdrawn ready, otherwise a
          // stale ready would complete the next operation immediately.
          if (!calc_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_accept     = req_accept_q;
  assign resp_valid     = resp_valid_q;
  assign resp_resultado = resp_resultado_q;
  assign resp_error     = resp_error_q;
  assign ocupado        = (state_q != ST_IDLE);
  assign calc_datoA     = calc_datoA_q;
  assign calc_datoB     = calc_datoB_q;
  assign calc_operacion = calc_operacion_q;
  assign calc_start     = calc_start_q;

endmodule

// File: tb/tb_arbitro_calculadora.sv
// -----------------------------------------------------------------------------
// tb_arbitro_calculadora
// Scoreboard bench: stimulus pushes expected accepts/responses into queues,
// monitors pop and compare when the DUT pulses req_accept / resp_valid.
// Includes a cycle-based model of the Ensamblador unit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arbitro_calculadora;
  import calc_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_datoA = '0;
  logic [N*DW-1:0]   req_datoB = '0;
  logic [N*3-1:0]    req_operacion = '0;
  logic [N-1:0]      req_accept;
  logic [N-1:0]      resp_valid;
  logic [DW-1:0]     resp_resultado;
  logic              resp_error;
  logic              ocupado;
  logic [DW-1:0]     calc_datoA;
  logic [DW-1:0]     calc_datoB;
  logic [2:0]        calc_operacion;
  logic              calc_start;
  logic [DW-1:0]     calc_resultado;
  logic              calc_ready;
  logic              calc_error;

  always #5 clk = ~clk;

  arbitro_calculadora #(
    .N       (N),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_datoA      (req_datoA),
    .req_datoB      (req_datoB),
    .req_operacion  (req_operacion),
    .req_accept     (req_accept),
    .resp_valid     (resp_valid),
    .resp_resultado (resp_resultado),
    .resp_error     (resp_error),
    .ocupado        (ocupado),
    .calc_datoA     (calc_datoA),
    .calc_datoB     (calc_datoB),
    .calc_operacion (calc_operacion),
    .calc_start     (calc_start),
    .calc_resultado (calc_resultado),
    .calc_ready     (calc_ready),
    .calc_error     (calc_error)
  );

  // ---------------- bookkeeping ----------------
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- unit model ----------------
  int lat   = 10;  // cycles from calc_start visible to calc_ready visible
  int hold  = 0;   // extra cycles ready lingers after start drops
  bit never = 1'b0;
  int mcnt;
  int hcnt;

  function automatic logic [DW:0] unit_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [2:0] op);
    case (op)
      OP_SUMA:  return {1'b0, a + b};
      OP_RESTA: return {1'b0, a - b};
      OP_MULT:  return {1'b0, a * b};
      OP_AND:   return {1'b0, a & b};
      OP_DIV:   return (b == 0) ? {1'b1, {DW{1'b0}}} : {1'b0, a / b};
      OP_OR:    return {1'b0, a | b};
      OP_XOR:   return {1'b0, a ^ b};
      default:  return {1'b0, a};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_ready     <= 1'b0;
      calc_resultado <= '0;
      calc_error     <= 1'b0;
      mcnt           <= 0;
      hcnt           <= 0;
    end else if (calc_start && !calc_ready) begin
      if (!never) begin
        if (mcnt >= lat - 1) begin
          {calc_error, calc_resultado} <= unit_f(calc_datoA, calc_datoB, calc_operacion);
          calc_ready <= 1'b1;
          mcnt       <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end else if (calc_ready && !calc_start) begin
      if (hcnt >= hold) begin
        calc_ready <= 1'b0;
        hcnt       <= 0;
      end else begin
        hcnt <= hcnt + 1;
      end
    end
  end

  // ---------------- scoreboard queues ----------------
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
  } vec_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] res;
    logic          err;
  } exp_t;

  vec_t pend [N][$];
  int   exp_acc [$];
  exp_t exp_resp [$];

  bit   loaded [N];
  int   raise_cyc [N];
  int   last_acc_lat = 0;
  int   last_acc_cyc = 0;
  int   last_resp_delay = 0;

  task automatic push_op(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [2:0] op, input logic [DW-1:0] er, input logic ee,
                         input bit want_resp);
    vec_t v;
    exp_t e;
    v.a = a; v.b = b; v.op = op;
    pend[r].push_back(v);
    exp_acc.push_back(r);
    if (want_resp) begin
      e.idx = r; e.res = er; e.err = ee;
      exp_resp.push_back(e);
    end
  endtask

  // Requester driver + accept monitor (both act on the negative edge).
  always @(negedge clk) begin
    if (req_accept != '0) begin
      int ai;
      ai = onehot_idx(req_accept);
      chk("accept_onehot", 64'($onehot(req_accept)), 64'd1);
      chk("accept_ready_low", 64'(calc_ready), 64'd0);
      if (exp_acc.size() == 0) begin
        chk("accept_unexpected", 64'(ai), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        int ei;
        ei = exp_acc.pop_front();
        chk("accept_index", 64'(ai), 64'(ei));
      end
      if (ai >= 0) begin
        last_acc_lat = cyc - raise_cyc[ai];
        last_acc_cyc = cyc;
        if (pend[ai].size() > 0) void'(pend[ai].pop_front());
        loaded[ai] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() == 0) begin
        loaded[i] = 1'b0;
      end else if (!loaded[i]) begin
        req_datoA[i*DW +: DW]   = pend[i][0].a;
        req_datoB[i*DW +: DW]   = pend[i][0].b;
        req_operacion[i*3 +: 3] = pend[i][0].op;
        loaded[i]    = 1'b1;
        raise_cyc[i] = cyc;
      end
      req_valid[i] = loaded[i];
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (resp_valid != '0) begin
      int ri;
      ri = onehot_idx(resp_valid);
      chk("resp_onehot", 64'($onehot(resp_valid)), 64'd1);
      if (exp_resp.size() == 0) begin
        chk("resp_unexpected", 64'(ri), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_resp.pop_front();
        chk("resp_index", 64'(ri), 64'(e.idx));
        chk("resp_result", 64'(resp_resultado), 64'(e.res));
        chk("resp_error", 64'(resp_error), 64'(e.err));
      end
      last_resp_delay = cyc - last_acc_cyc;
    end
  end

  // calc_start run length and operand stability while the unit is busy.
  int            start_run = 0;
  int            last_start_len = 0;
  bit            unstable = 1'b0;
  logic [DW-1:0] snap_a;
  logic [DW-1:0] snap_b;
  logic [2:0]    snap_op;

  always @(negedge clk) begin
    if (calc_start) begin
      if (start_run == 0) begin
        snap_a   = calc_datoA;
        snap_b   = calc_datoB;
        snap_op  = calc_operacion;
        unstable = 1'b0;
      end else if (calc_datoA !== snap_a || calc_datoB !== snap_b || calc_operacion !== snap_op) begin
        unstable = 1'b1;
      end
      start_run++;
    end else if (start_run > 0) begin
      last_start_len = start_run;
      start_run      = 0;
      chk("operands_stable", 64'(unstable), 64'd0);
    end
  end

  function automatic bit tb_busy();
    bit b;
    b = ocupado || (exp_acc.size() != 0) || (exp_resp.size() != 0);
    for (int i = 0; i < N; i++) if (pend[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_done(input string nm, input int budget);
    int t;
    t = 0;
    while (tb_busy() && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(nm, 64'(tb_busy()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_accept", 64'(req_accept), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_resultado", 64'(resp_resultado), 64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    chk("rst_ocupado", 64'(ocupado), 64'd0);
    chk("rst_calc_datoA", 64'(calc_datoA), 64'd0);
    chk("rst_calc_datoB", 64'(calc_datoB), 64'd0);
    chk("rst_calc_operacion", 64'(calc_operacion), 64'd0);
    chk("rst_calc_start", 64'(calc_start), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_request", 64'(ocupado), 64'd0);

    // Single request: 5 / 500 = 0, no error.
    lat = 10; hold = 0;
    @(posedge clk); #1;
    push_op(0, 32'd5, 32'd500, OP_DIV, 32'd0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("single_ocupado", 64'(ocupado), 64'd1);
    chk("single_calc_start", 64'(calc_start), 64'd1);
    wait_done("single_done", 200);
    chk("single_accept_latency", 64'(last_acc_lat), 64'd1);
    // ready shows lat cycles after start; the arbiter drops start on the
    // following edge, so start is seen high for lat+1 cycles.
    chk("single_start_len", 64'(last_start_len), 64'(lat + 1));
    chk("single_resp_delay", 64'(last_resp_delay), 64'(lat + 1));

    // Reset in the middle of ESPERA: no response for that operation.
    lat = 10;
    @(posedge clk); #1;
    push_op(2, 32'd11, 32'd22, OP_SUMA, 32'd0, 1'b0, 1'b0);
    begin
      int t;
      t = 0;
      while (!ocupado && t < 20) begin
        @(posedge clk); #1; t++;
      end
      chk("rstmid_reached_espera", 64'(ocupado), 64'd1);
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_calc_start_async", 64'(calc_start), 64'd0);
    chk("rstmid_ocupado", 64'(ocupado), 64'd0);
    chk("rstmid_calc_datoA", 64'(calc_datoA), 64'd0);
    for (int i = 0; i < N; i++) pend[i].delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Contention: all four requesters, requester 0 re-requests once.
    // Grant order after reset: 0,1,2,3,0.
    lat = 2; hold = 0;
    @(posedge clk); #1;
    push_op(0, 32'd7,   32'd8,  OP_SUMA,  32'd15, 1'b0, 1'b1);
    push_op(1, 32'd20,  32'd6,  OP_RESTA, 32'd14, 1'b0, 1'b1);
    push_op(2, 32'd6,   32'd7,  OP_MULT,  32'd42, 1'b0, 1'b1);
    push_op(3, 32'd100, 32'd4,  OP_DIV,   32'd25, 1'b0, 1'b1);
    push_op(0, 32'd240, 32'd60, OP_AND,   32'd48, 1'b0, 1'b1);
    wait_done("contention_done", 400);

    // Unit error on divide by zero, then a clean divide.
    lat = 4;
    @(posedge clk); #1;
    push_op(1, 32'd9, 32'd0, OP_DIV, 32'd0, 1'b1, 1'b1);
    push_op(1, 32'd9, 32'd3, OP_DIV, 32'd3, 1'b0, 1'b1);
    wait_done("error_done", 200);

    // Ready lingers after start drops: next accept must wait for ready low.
    lat = 1; hold = 3;
    @(posedge clk); #1;
    push_op(2, 32'd3,  32'd4, OP_SUMA, 32'd7,  1'b0, 1'b1);
    push_op(3, 32'd10, 32'd3, OP_MULT, 32'd30, 1'b0, 1'b1);
    wait_done("handshake_done", 200);
    repeat (4) @(posedge clk);
    #1;
    chk("resp_hold_resultado", 64'(resp_resultado), 64'd30);
    chk("resp_hold_error", 64'(resp_error), 64'd0);
    hold = 0;

`ifdef CALC_TIMEOUT_EN
    // Unit never answers: watchdog completes with error after TO+1 cycles.
    never = 1'b1;
    @(posedge clk); #1;
    push_op(0, 32'd1, 32'd2, OP_SUMA, 32'd0, 1'b1, 1'b1);
    wait_done("timeout_done", 100);
    chk("timeout_resp_delay", 64'(last_resp_delay), 64'(TO + 1));
    never = 1'b0;
    lat   = 3;
    @(posedge clk); #1;
    push_op(1, 32'd3, 32'd4, OP_SUMA, 32'd7, 1'b0, 1'b1);
    wait_done("after_timeout_done", 100);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
